// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: NOP encoding, fetch stride,
// fetch state encoding and default reset / exception vector addresses.
// Latency: n/a (definitions only). Backpressure: n/a.
package if_fetch_unit_pkg;

    localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;
    localparam logic [31:0] INSTR_BYTES    = 32'd4;
    localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_0020;

    // HOLD: ROM disabled for the first cycle after reset; RUN: normal fetching.
    typedef enum logic {
        ST_HOLD = 1'b0,
        ST_RUN  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/if_fetch_unit_if_id_reg.sv
// IF/ID pipeline register: captures pc/instr/valid of the fetched word for decode.
// Latency: 1 cycle from load to outputs. Backpressure: hold freezes contents; squash wins over hold.
// Ports: clk, rst (async, active-high); squash/hold/load controls; pc_in/instr_in;
//        pc_out/instr_out/valid_out. With no control asserted the contents are kept.
module if_fetch_unit_if_id_reg
    import if_fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        squash,
    input  logic        hold,
    input  logic        load,
    input  logic [31:0] pc_in,
    input  logic [31:0] instr_in,
    output logic [31:0] pc_out,
    output logic [31:0] instr_out,
    output logic        valid_out
);

    logic [31:0] pc_q,    pc_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        if (squash) begin
            // Squashed slot carries a NOP; pc is zeroed so a bubble is unambiguous.
            pc_d    = 32'h0;
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (hold) begin
            pc_d    = pc_q;
            instr_d = instr_q;
            valid_d = valid_q;
        end else if (load) begin
            pc_d    = pc_in;
            instr_d = instr_in;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= 32'h0;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    assign pc_out    = pc_q;
    assign instr_out = instr_q;
    assign valid_out = valid_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: owns the PC, drives the combinational instruction ROM, fills IF/ID.
// Latency: 1 cycle from rom_addr to id_instr. Backpressure: stall freezes PC and IF/ID; flush overrides stall.
// Ports: clk, rst (async, active-high); stall, flush, branch_taken, branch_target in;
//        rom_ce/rom_addr out, rom_instr in; id_pc/id_instr/id_valid out; fetch_fault out.
// Optional build macro FETCH_ALIGN_CHECK_EN: a misaligned redirect goes to EXC_VECTOR and
// pulses fetch_fault for one cycle. Without it the target low bits are cleared and
// fetch_fault is tied low.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        rom_ce,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic        id_valid,
    output logic        fetch_fault
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         ifid_squash;
    logic         ifid_hold;
    logic         ifid_load;
    logic         fault_set;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_HOLD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: HOLD lasts exactly one cycle after reset release.
    always_comb begin
        state_d = state_q;
        if (state_q == ST_HOLD) begin
            state_d = ST_RUN;
        end
    end

    // Output / datapath control, first matching row wins: flush, stall, redirect, sequential.
    always_comb begin
        pc_d        = pc_q;
        ifid_squash = 1'b0;
        ifid_hold   = 1'b0;
        ifid_load   = 1'b0;
        fault_set   = 1'b0;
        if (state_q == ST_HOLD) begin
            ifid_squash = 1'b1;
        end else if (flush) begin
            pc_d        = EXC_VECTOR;
            ifid_squash = 1'b1;
        end else if (stall) begin
            // ID keeps branch_taken asserted across the stall, so it is safe to ignore here.
            ifid_hold   = 1'b1;
        end else if (branch_taken) begin
            ifid_squash = 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
            if (branch_target[1:0] != 2'b00) begin
                pc_d      = EXC_VECTOR;
                fault_set = 1'b1;
            end else begin
                pc_d      = branch_target;
            end
`else
            pc_d        = branch_target & ~32'h3;
`endif
        end else begin
            ifid_load   = 1'b1;
            // Natural 32-bit wrap from 0xFFFF_FFFC to 0.
            pc_d        = pc_q + INSTR_BYTES;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    logic fault_q, fault_d;

    // Single-cycle pulse: set only on the redirect edge, cleared on every other edge.
    always_comb begin
        fault_d = fault_set;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign fetch_fault = fault_q;
`else
    assign fetch_fault = fault_set & 1'b0;
`endif

    assign rom_ce   = (state_q == ST_RUN);
    assign rom_addr = {pc_q[31:2], 2'b00};

    if_fetch_unit_if_id_reg u_if_id_reg (
        .clk       (clk),
        .rst       (rst),
        .squash    (ifid_squash),
        .hold      (ifid_hold),
        .load      (ifid_load),
        .pc_in     (rom_addr),
        .instr_in  (rom_instr),
        .pc_out    (id_pc),
        .instr_out (id_instr),
        .valid_out (id_valid)
    );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a combinational ROM model (word i = 0x1000_0000 + i).
// Latency: n/a. Backpressure: stall/flush/branch driven directly by the stimulus.
module tb_if_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_instr;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic        id_valid;
    logic        fetch_fault;

    int checks   = 0;
    int failures = 0;

    if_fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .rom_ce        (rom_ce),
        .rom_addr      (rom_addr),
        .rom_instr     (rom_instr),
        .id_pc         (id_pc),
        .id_instr      (id_instr),
        .id_valid      (id_valid),
        .fetch_fault   (fetch_fault)
    );

    assign rom_instr = rom_ce ? (32'h1000_0000 + {2'b00, rom_addr[31:2]}) : 32'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_id(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                          input logic vld);
        chk32({tag, "_id_pc"}, id_pc, pc);
        chk32({tag, "_id_instr"}, id_instr, instr);
        chk1({tag, "_id_valid"}, id_valid, vld);
    endtask

    task automatic chk_reset(input string tag);
        chk1({tag, "_rom_ce"}, rom_ce, 1'b0);
        chk32({tag, "_rom_addr"}, rom_addr, 32'h0);
        chk_id(tag, 32'h0, 32'h0, 1'b0);
        chk1({tag, "_fault"}, fetch_fault, 1'b0);
    endtask

    initial begin
        rst           = 1'b1;
        stall         = 1'b0;
        flush         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;

        // Reset state, released between edges.
        #12;
        chk_reset("rst");
        rst = 1'b0;

        // Edge 1: ROM enabled, nothing valid yet.
        step();
        chk1("e1_rom_ce", rom_ce, 1'b1);
        chk32("e1_rom_addr", rom_addr, 32'h0);
        chk1("e1_id_valid", id_valid, 1'b0);

        // Edge 2: first valid instruction.
        step();
        chk_id("e2", 32'h0, 32'h1000_0000, 1'b1);
        chk32("e2_rom_addr", rom_addr, 32'h4);

        step();
        chk_id("e3", 32'h4, 32'h1000_0001, 1'b1);
        chk32("e3_rom_addr", rom_addr, 32'h8);

        // Stall three cycles at rom_addr=8.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk32("stall_rom_addr", rom_addr, 32'h8);
            chk_id("stall", 32'h4, 32'h1000_0001, 1'b1);
        end
        stall = 1'b0;
        step();
        chk_id("unstall", 32'h8, 32'h1000_0002, 1'b1);
        chk32("unstall_rom_addr", rom_addr, 32'hC);

        // Taken branch to 0x40 from rom_addr=12.
        branch_taken  = 1'b1;
        branch_target = 32'h40;
        step();
        chk_id("br", 32'h0, 32'h0, 1'b0);
        chk32("br_rom_addr", rom_addr, 32'h40);
        branch_taken = 1'b0;
        step();
        chk_id("br_tgt", 32'h40, 32'h1000_0010, 1'b1);
        chk32("br_tgt_rom_addr", rom_addr, 32'h44);

        // Flush + branch + stall together: flush wins.
        flush         = 1'b1;
        branch_taken  = 1'b1;
        stall         = 1'b1;
        branch_target = 32'h80;
        step();
        chk32("fl_rom_addr", rom_addr, 32'h20);
        chk_id("fl", 32'h0, 32'h0, 1'b0);
        flush        = 1'b0;
        branch_taken = 1'b0;
        stall        = 1'b0;
        step();
        chk_id("fl_vec", 32'h20, 32'h1000_0008, 1'b1);
        chk32("fl_vec_rom_addr", rom_addr, 32'h24);

        // Asynchronous reset between edges.
        #2;
        rst = 1'b1;
        #1;
        chk_reset("arst");
        #2;
        rst = 1'b0;
        step();
        chk1("rr_rom_ce", rom_ce, 1'b1);
        chk32("rr_rom_addr", rom_addr, 32'h0);
        chk1("rr_id_valid", id_valid, 1'b0);
        step();
        chk_id("rr_first", 32'h0, 32'h1000_0000, 1'b1);

        // PC wrap.
        branch_taken  = 1'b1;
        branch_target = 32'hFFFF_FFFC;
        step();
        chk32("wrap_pre_rom_addr", rom_addr, 32'hFFFF_FFFC);
        branch_taken = 1'b0;
        step();
        chk_id("wrap_top", 32'hFFFF_FFFC, 32'h4FFF_FFFF, 1'b1);
        chk32("wrap_rom_addr", rom_addr, 32'h0);
        chk1("wrap_fault", fetch_fault, 1'b0);
        step();
        chk_id("wrap_zero", 32'h0, 32'h1000_0000, 1'b1);

        // Misaligned redirect.
        branch_taken  = 1'b1;
        branch_target = 32'h42;
        step();
        chk1("mis_id_valid", id_valid, 1'b0);
`ifdef FETCH_ALIGN_CHECK_EN
        chk32("mis_rom_addr", rom_addr, 32'h20);
        chk1("mis_fault", fetch_fault, 1'b1);
`else
        chk32("mis_rom_addr", rom_addr, 32'h40);
        chk1("mis_fault", fetch_fault, 1'b0);
`endif
        branch_taken = 1'b0;
        step();
        chk1("mis_fault_clr", fetch_fault, 1'b0);
`ifdef FETCH_ALIGN_CHECK_EN
        chk_id("mis_next", 32'h20, 32'h1000_0008, 1'b1);
`else
        chk_id("mis_next", 32'h40, 32'h1000_0010, 1'b1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
